fetch_sequencer: RTL and testbench

Controller for the instruction-fetch stage.
- Sequences fetch-stage bring-up: halt, i-cache clear/reset, then streaming program load into the i-cache write port.
- Shares that write port between the boot-load stream and a debug writer.
- In run mode, converts execute-stage branch requests into a timed flush-then-redirect sequence on the fetch stage's flushBack/shouldBranch controls.

---
 rtl/fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch stage controller.
//                - Brings up the fetch stage: halt, i-cache clear, streaming
//                  program load.
//                - Shares the i-cache write port between the load stream and
//                  a debug writer; the load stream has priority.
//                - In run mode, turns execute-stage branch requests into a
//                  timed flush-then-redirect sequence.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro : FETCH_SEQ_DBG_WRITE_EN
//    defined   -> debug write port is active
//    undefined -> dbgWriteReady_o tied 0, debug inputs ignored
// ----------------------------------------------------------------------------
//  Ports
//    clock_i            in   system clock, all logic on posedge
//    reset_i            in   synchronous active-high reset
//    start_i            in   request program (re)load (IDLE and RUN only)
//    loadValid_i        in   load-stream beat valid
//    loadLast_i         in   final bundle of the load stream
//    loadData_i         in   load-stream bundle
//    loadReady_o        out  load-stream ready (combinational)
//    dbgWriteValid_i    in   debug write request
//    dbgWriteAddress_i  in   debug write address
//    dbgWriteData_i     in   debug write bundle
//    dbgWriteReady_o    out  debug write grant (combinational)
//    branchReq_i        in   branch request from execute
//    branchOffset_i     in   branch offset
//    branchDirection_i  in   0 = backward, 1 = forward
//    branchAck_o        out  one-cycle pulse, request captured
//    halt_o             out  fetch halt
//    fetchReset_o       out  fetch reset
//    writeEnable_o      out  i-cache write enable
//    writeAddress_o     out  i-cache write address
//    instruction_o      out  i-cache write data
//    flushBack_o        out  fetch flush
//    shouldBranch_o     out  fetch branch strobe
//    branchOffset_o     out  held redirect offset
//    branchDirection_o  out  held redirect direction
//    running_o          out  high in RUN only
// ============================================================================
module fetch_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int INSTR_WIDTH  = 60,
  parameter int LOAD_WORDS   = 256,
  parameter int FLUSH_CYCLES = 3    // legal range 1..15
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   loadValid_i,
  input  logic                   loadLast_i,
  input  logic [INSTR_WIDTH-1:0] loadData_i,
  output logic                   loadReady_o,
  input  logic                   dbgWriteValid_i,
  input  logic [ADDR_WIDTH-1:0]  dbgWriteAddress_i,
  input  logic [INSTR_WIDTH-1:0] dbgWriteData_i,
  output logic                   dbgWriteReady_o,
  input  logic                   branchReq_i,
  input  logic [ADDR_WIDTH-1:0]  branchOffset_i,
  input  logic                   branchDirection_i,
  output logic                   branchAck_o,
  output logic                   halt_o,
  output logic                   fetchReset_o,
  output logic                   writeEnable_o,
  output logic [ADDR_WIDTH-1:0]  writeAddress_o,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   flushBack_o,
  output logic                   shouldBranch_o,
  output logic [ADDR_WIDTH-1:0]  branchOffset_o,
  output logic                   branchDirection_o,
  output logic                   running_o
);

  // Counter is one bit wider than strictly needed so it can never wrap
  // even if it counts past the last legal word.
  localparam int c_cnt_width = $clog2(LOAD_WORDS + 1);
  localparam logic [c_cnt_width-1:0] c_last_word = c_cnt_width'(LOAD_WORDS - 1);
  localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RUN    = 3'd4,
    S_FLUSH  = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_cnt_width-1:0] r_load_count;
  logic [3:0]             r_flush_count;
  logic                   w_load_fire;
  logic                   w_dbg_fire;
  logic                   w_branch_take;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and combinational handshakes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    loadReady_o     = 1'b0;
    dbgWriteReady_o = 1'b0;
    w_branch_take   = 1'b0;

    if (r_state == S_LOAD) begin
      loadReady_o = 1'b1;
    end

`ifdef FETCH_SEQ_DBG_WRITE_EN
    // In IDLE the grant is withheld while start_i is high: the granted write
    // would otherwise land during the CLEAR cycle together with fetchReset_o.
    if (r_state == S_IDLE) begin
      dbgWriteReady_o = !start_i;
    end else if (r_state == S_LOAD) begin
      dbgWriteReady_o = !loadValid_i;
    end
`endif

    w_load_fire = loadValid_i && loadReady_o;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_load_fire && (loadLast_i || (r_load_count == c_last_word))) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (start_i) begin
          w_next_state = S_CLEAR;
        end else if (branchReq_i) begin
          w_branch_take = 1'b1;
          w_next_state  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_flush_count == 4'd0) begin
          w_next_state = S_BRANCH;
        end
      end
      S_BRANCH: begin
        w_next_state = S_RUN;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

`ifdef FETCH_SEQ_DBG_WRITE_EN
  assign w_dbg_fire = dbgWriteValid_i && dbgWriteReady_o;
`else
  assign w_dbg_fire = 1'b0;
  logic w_dbg_unused;
  assign w_dbg_unused = &{1'b0, dbgWriteValid_i, dbgWriteAddress_i, dbgWriteData_i};
`endif

  // --------------------------------------------------------------------------
  // Registered outputs. Control outputs are decoded from the next state so
  // that they are aligned with the state the controller is in.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      halt_o            <= 1'b1;
      fetchReset_o      <= 1'b0;
      writeEnable_o     <= 1'b0;
      writeAddress_o    <= '0;
      instruction_o     <= '0;
      flushBack_o       <= 1'b0;
      shouldBranch_o    <= 1'b0;
      branchOffset_o    <= '0;
      branchDirection_o <= 1'b0;
      branchAck_o       <= 1'b0;
      running_o         <= 1'b0;
      r_load_count      <= '0;
      r_flush_count     <= 4'd0;
    end else begin
      halt_o         <= (w_next_state == S_IDLE)  || (w_next_state == S_CLEAR) ||
                        (w_next_state == S_LOAD)  || (w_next_state == S_DRAIN);
      fetchReset_o   <= (w_next_state == S_CLEAR);
      running_o      <= (w_next_state == S_RUN);
      flushBack_o    <= (w_next_state == S_FLUSH);
      shouldBranch_o <= (w_next_state == S_BRANCH);
      branchAck_o    <= w_branch_take;

      if (w_branch_take) begin
        branchOffset_o    <= branchOffset_i;
        branchDirection_o <= branchDirection_i;
      end

      // Load and debug grants are mutually exclusive, so at most one fires.
      writeEnable_o <= w_load_fire || w_dbg_fire;
      if (w_load_fire) begin
        writeAddress_o <= ADDR_WIDTH'(r_load_count);
        instruction_o  <= loadData_i;
      end else if (w_dbg_fire) begin
        writeAddress_o <= dbgWriteAddress_i;
        instruction_o  <= dbgWriteData_i;
      end

      if (r_state == S_CLEAR) begin
        r_load_count <= '0;
      end else if (w_load_fire) begin
        r_load_count <= r_load_count + c_cnt_width'(1);
      end

      if (w_branch_take) begin
        r_flush_count <= c_flush_load;
      end else if ((r_state == S_FLUSH) && (r_flush_count != 4'd0)) begin
        r_flush_count <= r_flush_count - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer
//                (LOAD_WORDS = 4, FLUSH_CYCLES = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_DBG_WRITE_EN
  localparam bit c_dbg = 1'b1;
`else
  localparam bit c_dbg = 1'b0;
`endif

  // Control bit patterns: {halt, fetchReset, writeEnable, loadReady,
  //                        flushBack, shouldBranch, branchAck, running}
  localparam logic [7:0] c_idle     = 8'b1000_0000;
  localparam logic [7:0] c_clear    = 8'b1100_0000;
  localparam logic [7:0] c_load     = 8'b1001_0000;
  localparam logic [7:0] c_load_wr  = 8'b1011_0000;
  localparam logic [7:0] c_drain_wr = 8'b1010_0000;
  localparam logic [7:0] c_run      = 8'b0000_0001;
  localparam logic [7:0] c_flush1   = 8'b0000_1010;
  localparam logic [7:0] c_flush    = 8'b0000_1000;
  localparam logic [7:0] c_branch   = 8'b0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        loadValid = 1'b0;
  logic        loadLast = 1'b0;
  logic [59:0] loadData = '0;
  logic        loadReady;
  logic        dbgValid = 1'b0;
  logic [15:0] dbgAddr = '0;
  logic [59:0] dbgData = '0;
  logic        dbgReady;
  logic        branchReq = 1'b0;
  logic [15:0] branchOff = '0;
  logic        branchDir = 1'b0;
  logic        branchAck;
  logic        halt, fetchReset, writeEnable, flushBack, shouldBranch, running;
  logic [15:0] writeAddress;
  logic [59:0] instruction;
  logic [15:0] branchOffOut;
  logic        branchDirOut;
  logic [7:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign ctl = {halt, fetchReset, writeEnable, loadReady,
                flushBack, shouldBranch, branchAck, running};

  fetch_sequencer #(
    .ADDR_WIDTH(16), .INSTR_WIDTH(60), .LOAD_WORDS(4), .FLUSH_CYCLES(3)
  ) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start),
    .loadValid_i(loadValid), .loadLast_i(loadLast), .loadData_i(loadData),
    .loadReady_o(loadReady),
    .dbgWriteValid_i(dbgValid), .dbgWriteAddress_i(dbgAddr),
    .dbgWriteData_i(dbgData), .dbgWriteReady_o(dbgReady),
    .branchReq_i(branchReq), .branchOffset_i(branchOff),
    .branchDirection_i(branchDir), .branchAck_o(branchAck),
    .halt_o(halt), .fetchReset_o(fetchReset), .writeEnable_o(writeEnable),
    .writeAddress_o(writeAddress), .instruction_o(instruction),
    .flushBack_o(flushBack), .shouldBranch_o(shouldBranch),
    .branchOffset_o(branchOffOut), .branchDirection_o(branchDirOut),
    .running_o(running)
  );

  // Structural invariants, checked every cycle away from the clock edge.
  always @(negedge clock) begin
    n_checks++;
    if ((flushBack && shouldBranch) || (writeEnable && !halt) ||
        (fetchReset && writeEnable)) begin
      n_fail++;
      $display("FAIL invariant: flush=%b branch=%b we=%b halt=%b frst=%b required no overlap",
               flushBack, shouldBranch, writeEnable, halt, fetchReset);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== c_idle) begin
      n_fail++; $display("FAIL reset_ctl: got %b required %b", ctl, c_idle);
    end
    n_checks++;
    if ({writeAddress, instruction, branchOffOut, branchDirOut} !== 93'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h instr=%h off=%h dir=%b required 0",
                         writeAddress, instruction, branchOffOut, branchDirOut);
    end
    n_checks++;
    if (dbgReady !== c_dbg) begin
      n_fail++; $display("FAIL reset_dbg_ready: got %b required %b", dbgReady, c_dbg);
    end
  endtask

  task automatic test_load_basic();
    logic [59:0] data [3];
    data[0] = 60'hAAA_AAAA_AAAA_AAAA;
    data[1] = 60'hBBB_BBBB_BBBB_BBBB;
    data[2] = 60'hCCC_CCCC_CCCC_CCCC;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (ctl !== c_clear) begin
      n_fail++; $display("FAIL basic_clear: got %b required %b", ctl, c_clear);
    end
    tick();
    n_checks++;
    if (ctl !== c_load) begin
      n_fail++; $display("FAIL basic_load_entry: got %b required %b", ctl, c_load);
    end
    for (int k = 0; k < 3; k++) begin
      loadValid = 1'b1;
      loadLast  = (k == 2);
      loadData  = data[k];
      tick();
      n_checks++;
      if (ctl !== ((k == 2) ? c_drain_wr : c_load_wr) || writeAddress !== 16'(k) ||
          instruction !== data[k]) begin
        n_fail++; $display("FAIL basic_write%0d: ctl=%b addr=%h data=%h required addr=%h data=%h",
                           k, ctl, writeAddress, instruction, k, data[k]);
      end
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    tick();
    n_checks++;
    if (ctl !== c_run) begin
      n_fail++; $display("FAIL basic_run: got %b required %b", ctl, c_run);
    end
  endtask

  task automatic test_load_max();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (ctl !== c_clear) begin
      n_fail++; $display("FAIL max_clear: got %b required %b", ctl, c_clear);
    end
    tick();
    loadValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      loadData = 60'h100 + 60'(k);
      tick();
      n_checks++;
      if (ctl !== ((k == 3) ? c_drain_wr : c_load_wr) || writeAddress !== 16'(k) ||
          instruction !== (60'h100 + 60'(k))) begin
        n_fail++; $display("FAIL max_write%0d: ctl=%b addr=%h data=%h required addr=%h",
                           k, ctl, writeAddress, instruction, k);
      end
    end
    loadData = 60'h999;
    tick();
    n_checks++;
    if (ctl !== c_run || writeAddress !== 16'h0003) begin
      n_fail++; $display("FAIL max_no_fifth: ctl=%b addr=%h required ctl=%b addr=0003",
                         ctl, writeAddress, c_run);
    end
    loadValid = 1'b0;
  endtask

  task automatic test_dbg_arb();
    logic [15:0] exp_addr;
    logic [59:0] exp_data;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    loadValid = 1'b1;
    loadData  = 60'hD;
    dbgValid  = 1'b1;
    dbgAddr   = 16'h0020;
    dbgData   = 60'hE;
    #1;
    n_checks++;
    if (dbgReady !== 1'b0) begin
      n_fail++; $display("FAIL dbg_blocked: got %b required 0", dbgReady);
    end
    tick();
    n_checks++;
    if (ctl !== c_load_wr || writeAddress !== 16'h0000 || instruction !== 60'hD) begin
      n_fail++; $display("FAIL dbg_load_first: ctl=%b addr=%h data=%h required addr=0000 data=d",
                         ctl, writeAddress, instruction);
    end
    loadValid = 1'b0;
    #1;
    n_checks++;
    if (dbgReady !== c_dbg) begin
      n_fail++; $display("FAIL dbg_grant: got %b required %b", dbgReady, c_dbg);
    end
    tick();
    exp_addr = c_dbg ? 16'h0020 : 16'h0000;
    exp_data = c_dbg ? 60'hE : 60'hD;
    n_checks++;
    if (writeEnable !== c_dbg || writeAddress !== exp_addr || instruction !== exp_data) begin
      n_fail++; $display("FAIL dbg_write: we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                         writeEnable, writeAddress, instruction, c_dbg, exp_addr, exp_data);
    end
    dbgValid  = 1'b0;
    loadValid = 1'b1;
    loadLast  = 1'b1;
    loadData  = 60'hF;
    tick();
    n_checks++;
    if (ctl !== c_drain_wr || writeAddress !== 16'h0001 || instruction !== 60'hF) begin
      n_fail++; $display("FAIL dbg_last_load: ctl=%b addr=%h required ctl=%b addr=0001",
                         ctl, writeAddress, c_drain_wr);
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    branchReq = 1'b1;
    branchOff = 16'h000F;
    branchDir = 1'b1;
    tick();
    n_checks++;
    if (ctl !== c_flush1 || branchOffOut !== 16'h000F || branchDirOut !== 1'b1) begin
      n_fail++; $display("FAIL br_flush1: ctl=%b off=%h dir=%b required ctl=%b off=000f dir=1",
                         ctl, branchOffOut, branchDirOut, c_flush1);
    end
    // Second request while flushing must be ignored.
    branchOff = 16'h0033;
    branchDir = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      tick();
      n_checks++;
      if (ctl !== c_flush || branchOffOut !== 16'h000F) begin
        n_fail++; $display("FAIL br_flush%0d: ctl=%b off=%h required ctl=%b off=000f",
                           k, ctl, branchOffOut, c_flush);
      end
    end
    tick();
    branchReq = 1'b0;
    n_checks++;
    if (ctl !== c_branch || branchOffOut !== 16'h000F || branchDirOut !== 1'b1) begin
      n_fail++; $display("FAIL br_redirect: ctl=%b off=%h dir=%b required ctl=%b off=000f dir=1",
                         ctl, branchOffOut, branchDirOut, c_branch);
    end
    tick();
    n_checks++;
    if (ctl !== c_run) begin
      n_fail++; $display("FAIL br_back_to_run: got %b required %b", ctl, c_run);
    end
  endtask

  task automatic test_start_branch();
    start     = 1'b1;
    branchReq = 1'b1;
    branchOff = 16'h0055;
    tick();
    start     = 1'b0;
    branchReq = 1'b0;
    n_checks++;
    if (ctl !== c_clear || branchOffOut !== 16'h000F) begin
      n_fail++; $display("FAIL start_wins: ctl=%b off=%h required ctl=%b off=000f",
                         ctl, branchOffOut, c_clear);
    end
  endtask

  task automatic test_reset_mid();
    // Currently in CLEAR; enter LOAD and land a write, then reset.
    tick();
    loadValid = 1'b1;
    loadData  = 60'h777;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    loadValid = 1'b0;
    n_checks++;
    if (ctl !== c_idle || branchOffOut !== 16'h0000 || writeAddress !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_load: ctl=%b off=%h addr=%h required ctl=%b zeros",
                         ctl, branchOffOut, writeAddress, c_idle);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    loadValid = 1'b1;
    loadLast  = 1'b1;
    tick();
    loadValid = 1'b0;
    loadLast  = 1'b0;
    tick();
    branchReq = 1'b1;
    branchOff = 16'h0042;
    branchDir = 1'b1;
    tick();
    branchReq = 1'b0;
    tick();
    n_checks++;
    if (ctl !== c_flush) begin
      n_fail++; $display("FAIL reset_mid_pre: got %b required %b", ctl, c_flush);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (ctl !== c_idle || branchOffOut !== 16'h0000 || branchDirOut !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_flush: ctl=%b off=%h dir=%b required ctl=%b zeros",
                         ctl, branchOffOut, branchDirOut, c_idle);
    end
    tick();
    tick();
    n_checks++;
    if (ctl !== c_idle) begin
      n_fail++; $display("FAIL reset_stays_idle: got %b required %b", ctl, c_idle);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_max();
    test_dbg_arb();
    test_branch();
    test_start_branch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
